// File: rtl/lsu_bus_if_if.sv
// Bus-side signal bundle between the load/store unit and the data memory port.
// master = LSU (drives request/address/data), slave = memory (drives ack/read data).
interface lsu_bus_if_if;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        ACKD_n;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_be,
        output mem_wdata,
        input  mem_rdata,
        input  ACKD_n
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_be,
        input  mem_wdata,
        output mem_rdata,
        output ACKD_n
    );
endinterface

// File: rtl/lsu_bus_if.sv
// Load/store bus adapter: aligns and lane-replicates core accesses, runs one bus cycle
// with an acknowledge timeout, and returns an aligned, extended load result.
module lsu_bus_if #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MREQ,
    input  logic        WRITE,
    input  logic [1:0]  SIZE,
    input  logic [31:0] DAD,
    input  logic [31:0] wdata,
    input  logic        ld_unsigned,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    lsu_bus_if_if.master bus
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone, StErr} state_e;

    localparam logic [1:0] SzWord = 2'b00;
    localparam logic [1:0] SzHalf = 2'b01;
    localparam logic [1:0] SzByte = 2'b10;

    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q;
    logic [29:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic        uns_q;
    logic [31:0] rdata_q;

    logic        illegal;
    logic        ack;
    logic [3:0]  be_new;
    logic [31:0] wdata_rep;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_val;

    assign ack = ~bus.ACKD_n;

    assign illegal = (SIZE == 2'b11) ||
                     (SIZE == SzHalf && DAD[0]) ||
                     (SIZE == SzWord && DAD[1:0] != 2'b00);

    // Lane enables and replicated store data, computed from the request as presented.
    always_comb begin
        be_new    = 4'b1111;
        wdata_rep = wdata;
        case (SIZE)
            SzByte: begin
                be_new    = 4'b0001 << DAD[1:0];
                wdata_rep = {4{wdata[7:0]}};
            end
            SzHalf: begin
                be_new    = DAD[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_rep = wdata;
            end
        endcase
    end

    // Lane selection and extension of the returned bus word.
    always_comb begin
        lane_b = bus.mem_rdata[7:0];
        case (off_q)
            2'd0: lane_b = bus.mem_rdata[7:0];
            2'd1: lane_b = bus.mem_rdata[15:8];
            2'd2: lane_b = bus.mem_rdata[23:16];
            default: lane_b = bus.mem_rdata[31:24];
        endcase
        lane_h = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (size_q)
            SzByte:  load_val = uns_q ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
            SzHalf:  load_val = uns_q ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_val = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (MREQ) begin
                    state_d = illegal ? StErr : StAccess;
                end
            end
            StAccess: begin
                // Ack takes priority over a timeout landing in the same cycle.
                if (ack) begin
                    state_d = StDone;
                end else if (cnt_q == CntLast) begin
                    state_d = StErr;
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy        = ((state_q == StIdle) && MREQ && rst) || (state_q == StAccess);
        done        = (state_q == StDone) || (state_q == StErr);
        err         = (state_q == StErr);
        bus.mem_req = (state_q == StAccess);
        bus.mem_we  = (state_q == StAccess) && we_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= 8'd0;
            addr_q  <= 30'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            off_q   <= 2'b00;
            uns_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            if (state_q == StIdle && MREQ && !illegal) begin
                cnt_q   <= 8'd0;
                addr_q  <= DAD[31:2];
                be_q    <= be_new;
                wdata_q <= wdata_rep;
                we_q    <= WRITE;
                size_q  <= SIZE;
                off_q   <= DAD[1:0];
                uns_q   <= ld_unsigned;
            end
            if (state_q == StAccess && !ack) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (state_q == StAccess && ack) begin
                rdata_q <= we_q ? 32'd0 : load_val;
            end else if (state_d == StErr) begin
                rdata_q <= 32'd0;
            end
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_be    = be_q;
    assign bus.mem_wdata = wdata_q;
    assign rdata         = rdata_q;

endmodule

// File: tb/tb_lsu_bus_if.sv
// Directed bench for lsu_bus_if: loads/stores of each size, alignment errors,
// acknowledge timeout and its boundary, and asynchronous reset mid-access.
module tb_lsu_bus_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        MREQ;
    logic        WRITE;
    logic [1:0]  SIZE;
    logic [31:0] DAD;
    logic [31:0] wdata;
    logic        ld_unsigned;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;

    int checks = 0;
    int errors = 0;

    lsu_bus_if_if bus ();

    lsu_bus_if #(
        .TIMEOUT (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .MREQ        (MREQ),
        .WRITE       (WRITE),
        .SIZE        (SIZE),
        .DAD         (DAD),
        .wdata       (wdata),
        .ld_unsigned (ld_unsigned),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .rdata       (rdata),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic req(input logic we, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input logic uns);
        MREQ        = 1'b1;
        WRITE       = we;
        SIZE        = sz;
        DAD         = a;
        wdata       = wd;
        ld_unsigned = uns;
    endtask

    int busy_n;
    int req_n;

    initial begin
        rst            = 1'b0;
        MREQ           = 1'b0;
        WRITE          = 1'b0;
        SIZE           = 2'b00;
        DAD            = 32'd0;
        wdata          = 32'd0;
        ld_unsigned    = 1'b0;
        bus.ACKD_n     = 1'b1;
        bus.mem_rdata  = 32'd0;

        // Reset state
        #3;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_mem_req", bus.mem_req, 1'b0);
        chk1("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // Signed byte load at offset 3, two wait cycles
        busy_n = 0;
        req(1'b0, 2'b10, 32'h0000_1003, 32'd0, 1'b0);
        #1;
        busy_n += int'(busy);
        tick();
        MREQ = 1'b0;
        chk1("lb_mem_req", bus.mem_req, 1'b1);
        chk1("lb_mem_we", bus.mem_we, 1'b0);
        chk("lb_mem_be", 32'(bus.mem_be), 32'h8);
        chk("lb_mem_addr", 32'(bus.mem_addr), 32'h400);
        busy_n += int'(busy);
        tick();
        busy_n += int'(busy);
        tick();
        bus.ACKD_n    = 1'b0;
        bus.mem_rdata = 32'h80FF_FF00;
        #1;
        busy_n += int'(busy);
        tick();
        bus.ACKD_n = 1'b1;
        busy_n += int'(busy);
        chk1("lb_done", done, 1'b1);
        chk1("lb_err", err, 1'b0);
        chk1("lb_mem_req_off", bus.mem_req, 1'b0);
        chk("lb_rdata", rdata, 32'hFFFF_FF80);
        chk("lb_busy_cycles", busy_n, 4);
        tick();
        chk1("lb_done_one_cycle", done, 1'b0);
        chk("lb_rdata_held", rdata, 32'hFFFF_FF80);

        // Halfword store, immediate ack
        req(1'b1, 2'b01, 32'h0000_2002, 32'h1234_ABCD, 1'b0);
        tick();
        MREQ       = 1'b0;
        bus.ACKD_n = 1'b0;
        chk1("sh_mem_req", bus.mem_req, 1'b1);
        chk1("sh_mem_we", bus.mem_we, 1'b1);
        chk("sh_mem_be", 32'(bus.mem_be), 32'hC);
        chk("sh_mem_wdata", bus.mem_wdata, 32'hABCD_ABCD);
        chk("sh_mem_addr", 32'(bus.mem_addr), 32'h800);
        tick();
        bus.ACKD_n = 1'b1;
        chk1("sh_done", done, 1'b1);
        chk1("sh_err", err, 1'b0);
        chk("sh_rdata", rdata, 32'd0);
        tick();

        // Byte store lane replication
        req(1'b1, 2'b10, 32'h0000_2001, 32'h0000_005A, 1'b0);
        tick();
        MREQ       = 1'b0;
        bus.ACKD_n = 1'b0;
        chk("sb_mem_be", 32'(bus.mem_be), 32'h2);
        chk("sb_mem_wdata", bus.mem_wdata, 32'h5A5A_5A5A);
        tick();
        bus.ACKD_n = 1'b1;
        tick();

        // Misaligned word: no bus cycle, error pulse
        req(1'b0, 2'b00, 32'h0000_3001, 32'd0, 1'b0);
        #1;
        chk1("mis_busy_idle", busy, 1'b1);
        tick();
        MREQ = 1'b0;
        chk1("mis_mem_req", bus.mem_req, 1'b0);
        chk1("mis_done", done, 1'b1);
        chk1("mis_err", err, 1'b1);
        chk1("mis_busy", busy, 1'b0);
        chk("mis_rdata", rdata, 32'd0);
        tick();
        chk1("mis_err_one_cycle", err, 1'b0);

        // Odd halfword and reserved size
        req(1'b0, 2'b01, 32'h0000_3003, 32'd0, 1'b0);
        tick();
        MREQ = 1'b0;
        chk1("odd_half_err", err, 1'b1);
        chk1("odd_half_mem_req", bus.mem_req, 1'b0);
        tick();
        req(1'b0, 2'b11, 32'h0000_5000, 32'd0, 1'b0);
        tick();
        MREQ = 1'b0;
        chk1("rsv_size_err", err, 1'b1);
        tick();

        // Timeout with ack never arriving
        req(1'b0, 2'b00, 32'h0000_6000, 32'd0, 1'b0);
        tick();
        MREQ  = 1'b0;
        req_n = 0;
        for (int i = 0; i < 40 && bus.mem_req; i++) begin
            req_n++;
            tick();
        end
        chk("to_req_cycles", req_n, 15);
        chk1("to_done", done, 1'b1);
        chk1("to_err", err, 1'b1);
        chk1("to_mem_req", bus.mem_req, 1'b0);
        chk("to_rdata", rdata, 32'd0);
        tick();

        // Ack on the cycle the counter would reach TIMEOUT
        req(1'b0, 2'b00, 32'h0000_6004, 32'd0, 1'b0);
        tick();
        MREQ = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
        end
        chk1("edge_still_req", bus.mem_req, 1'b1);
        bus.ACKD_n    = 1'b0;
        bus.mem_rdata = 32'hDEAD_BEEF;
        tick();
        bus.ACKD_n = 1'b1;
        chk1("edge_done", done, 1'b1);
        chk1("edge_err", err, 1'b0);
        chk("edge_rdata", rdata, 32'hDEAD_BEEF);
        tick();

        // Unsigned upper halfword load
        req(1'b0, 2'b01, 32'h0000_4002, 32'd0, 1'b1);
        tick();
        MREQ          = 1'b0;
        bus.ACKD_n    = 1'b0;
        bus.mem_rdata = 32'hF00D_0000;
        chk("lhu_mem_be", 32'(bus.mem_be), 32'hC);
        tick();
        bus.ACKD_n = 1'b1;
        chk("lhu_rdata", rdata, 32'h0000_F00D);
        tick();

        // Signed lower halfword load
        req(1'b0, 2'b01, 32'h0000_4000, 32'd0, 1'b0);
        tick();
        MREQ          = 1'b0;
        bus.ACKD_n    = 1'b0;
        bus.mem_rdata = 32'h1234_8001;
        chk("lh_mem_be", 32'(bus.mem_be), 32'h3);
        tick();
        bus.ACKD_n = 1'b1;
        chk("lh_rdata", rdata, 32'hFFFF_8001);
        tick();

        // Stray ack while idle has no effect
        bus.ACKD_n = 1'b0;
        tick();
        chk1("stray_ack_done", done, 1'b0);
        chk1("stray_ack_mem_req", bus.mem_req, 1'b0);
        bus.ACKD_n = 1'b1;
        tick();

        // Reset during the wait phase of an access
        req(1'b0, 2'b00, 32'h0000_7000, 32'd0, 1'b0);
        tick();
        MREQ = 1'b0;
        tick();
        chk1("rma_req_before", bus.mem_req, 1'b1);
        #1;
        rst = 1'b0;
        #1;
        chk1("rma_mem_req", bus.mem_req, 1'b0);
        chk1("rma_busy", busy, 1'b0);
        chk("rma_rdata", rdata, 32'd0);
        tick();
        chk1("rma_no_done", done, 1'b0);
        tick();
        rst = 1'b1;
        req(1'b0, 2'b10, 32'h0000_8001, 32'd0, 1'b1);
        tick();
        MREQ          = 1'b0;
        chk1("post_rst_first_edge", bus.mem_req, 1'b1);
        chk("post_rst_mem_be", 32'(bus.mem_be), 32'h2);
        bus.ACKD_n    = 1'b0;
        bus.mem_rdata = 32'h0000_AB00;
        tick();
        bus.ACKD_n = 1'b1;
        chk1("post_rst_done", done, 1'b1);
        chk("post_rst_rdata", rdata, 32'h0000_00AB);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Whole-run watchdog; every wait above is already bounded.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lsu_bus_if.md
LSU_BUS_IF -- requirements
Module: lsu_bus_if

Interface
REQ-001 Parameter TIMEOUT, default 15, maximum wait cycles for ACKD_n before abort (range 1..255).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 MREQ  in  1  core requests a data access this cycle.
REQ-005 WRITE  in  1  1 = store, 0 = load; valid with MREQ.
REQ-006 SIZE  in  2  access size: 00 word, 01 halfword, 10 byte, 11 reserved.
REQ-007 DAD  in  32  byte address from core ALU.
REQ-008 wdata  in  32  store data from core rs2, right-aligned.
REQ-009 ld_unsigned  in  1  1 = zero-extend load result, 0 = sign-extend.
REQ-010 busy  out  1  stall request to core PC/pipeline enable.
REQ-011 done  out  1  one-cycle pulse: access finished, rdata valid.
REQ-012 err  out  1  one-cycle pulse with done: misaligned, reserved SIZE, or timeout.
REQ-013 rdata  out  32  aligned, extended load result.
REQ-014 mem_req  out  1  bus request, held until ack or abort.
REQ-015 mem_we  out  1  bus write strobe, valid with mem_req.
REQ-016 mem_addr  out  30  word address DAD[31:2], registered.
REQ-017 mem_be  out  4  byte-lane enables, registered.
REQ-018 mem_wdata  out  32  lane-replicated store data, registered.
REQ-019 mem_rdata  in  32  bus read data, valid when ACKD_n=0.
REQ-020 ACKD_n  in  1  bus acknowledge, active-low.

Function
REQ-021 FSM states IDLE, ACCESS, DONE, ERR; encoding free.
REQ-022 IDLE: MREQ=1 and legal/aligned -> latch address, be, wdata, WRITE, SIZE, ld_unsigned; go ACCESS.
REQ-023 IDLE: MREQ=1 and illegal (SIZE=11, half with DAD[0]=1, word with DAD[1:0]!=0) -> go ERR; no bus cycle.
REQ-024 ACCESS: mem_req=1; ACKD_n=0 -> capture mem_rdata (loads), go DONE.
REQ-025 ACCESS: wait counter increments each cycle ACKD_n=1; at count == TIMEOUT -> go ERR, drop mem_req.
REQ-026 DONE and ERR last exactly one cycle, then IDLE unconditionally; MREQ sampled only in IDLE.
REQ-027 busy = (IDLE and MREQ) or ACCESS; deasserted in DONE and ERR so core advances that cycle.
REQ-028 done=1 in DONE and ERR; err=1 only in ERR.
REQ-029 mem_be little-endian: byte -> 1<<DAD[1:0]; half -> 0011 if DAD[1]=0 else 1100; word -> 1111.
REQ-030 mem_wdata: byte replicated 4x from wdata[7:0]; half replicated 2x from wdata[15:0]; word unchanged.
REQ-031 rdata load: select lane(s) per latched DAD[1:0]/SIZE, extend to 32 bits per ld_unsigned; stores leave rdata 0.
REQ-032 rdata is registered, valid in DONE, held until next DONE/ERR; ERR sets rdata 0.
REQ-033 ACKD_n=0 outside ACCESS is ignored.
REQ-034 Ack on the same cycle the counter reaches TIMEOUT: ack wins, go DONE.
REQ-035 Wait counter clears on entering ACCESS; width 8 bits.

Reset
REQ-036 rst=0 asynchronously forces IDLE, counter 0, busy/done/err/mem_req/mem_we 0, mem_addr/mem_be/mem_wdata/rdata 0.
REQ-037 rst asserted mid-ACCESS aborts immediately; mem_req drops without waiting for clk; no done pulse follows.
REQ-038 After rst release, first MREQ sampled on the first rising edge.

Verification
REQ-039 Load byte signed: DAD=0x1003, SIZE=10, mem_rdata=0x80FF_FF00, ack after 2 waits -> mem_be=1000, rdata=0xFFFF_FF80, done 1 cycle, busy 4 cycles total.
REQ-040 Store half: DAD=0x2002, SIZE=01, wdata=0x1234_ABCD, immediate ack -> mem_be=1100, mem_wdata=0xABCD_ABCD, mem_we=1, done next cycle.
REQ-041 Misaligned word: DAD=0x3001, SIZE=00 -> mem_req never asserts, ERR next cycle: done=1, err=1, rdata=0.
REQ-042 Timeout: TIMEOUT=15, ACKD_n held 1 -> mem_req high 15 cycles, then err+done pulse, mem_req 0.
REQ-043 Load half unsigned: DAD=0x4002, mem_rdata=0xF00D_0000, ld_unsigned=1 -> rdata=0x0000_F00D.
REQ-044 Reset mid-access: rst=0 during ACCESS wait -> mem_req and busy 0 immediately; no done; new load after release completes normally.
